serial_framer: RTL and testbench
================================

SERIAL_FRAMER -- requirements
Module: serial_framer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the number of data bits per frame (WIDTH >= 1).
REQ-002 The block SHALL have parameter DIV, default 4, giving the number of Clock cycles per transmitted bit (DIV >= 1).
REQ-003 The block SHALL have parameter PARITY_EN, default 1; 1 inserts an even-parity bit and 0 omits it.
REQ-004 The block SHALL have port Clock, input, width 1: the single clock; all state updates occur on its rising edge.
REQ-005 The block SHALL have port Reset, input, width 1: synchronous, active-low reset, sampled on the rising edge of Clock.
REQ-006 The block SHALL have port D, input, width WIDTH: the parallel word to transmit, typically the Q output of the upstream shift register.
REQ-007 The block SHALL have port Valid, input, width 1: D is offered for transmission.
REQ-008 The block SHALL have port Ready, output, width 1: the block can accept a word this cycle.
REQ-009 The block SHALL have port Tx, output, width 1: the serial line, which idles high.
REQ-010 The block SHALL have port Busy, output, width 1: a frame is in progress.
REQ-011 The block SHALL have port Done, output, width 1: a one-cycle pulse marking frame completion.

Function
REQ-012 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; all outputs SHALL be registered or decoded from state only.
REQ-013 In IDLE, Ready SHALL be 1, Busy 0 and Tx 1; in every other state, Ready SHALL be 0 and Busy 1.
REQ-014 A word SHALL be accepted on a rising edge where Valid=1 and Ready=1; D is copied into an internal WIDTH-bit shift register, and the FSM goes to START with the divider cleared.
REQ-015 Valid SHALL be ignored whenever Ready=0; D may change freely after acceptance without affecting the frame.
REQ-016 Tx SHALL be 0 in START, 1 in STOP, the even-parity bit (XOR of all latched bits) in PARITY, and the current LSB of the internal register in DATA.
REQ-017 Each of START, each DATA bit, PARITY and STOP SHALL last exactly DIV cycles, timed by a divider counter of 0..DIV-1 that wraps to 0 at each bit boundary.
REQ-018 In DATA, the internal register SHALL shift right by one at each bit boundary, transmitting LSB first; a bit counter of width ceil(log2(WIDTH+1)) SHALL count 0..WIDTH-1.
REQ-019 Transitions SHALL occur only at bit boundaries: START->DATA; DATA->PARITY after bit WIDTH-1 when PARITY_EN=1, otherwise DATA->STOP; PARITY->STOP; STOP->IDLE.
REQ-020 On the STOP->IDLE edge, Done SHALL be 1 for exactly the following cycle, coinciding with Ready=1; Done SHALL be 0 at all other times.
REQ-021 Latency SHALL be as follows: Tx=0 in the first cycle after the accept edge, and the frame occupies (WIDTH+2+PARITY_EN)*DIV cycles before returning to IDLE.
REQ-022 Back-to-back frames: if Valid is held 1, the next word SHALL be accepted in the Done cycle, so exactly one idle cycle (Tx=1) separates the frames.
REQ-023 With DIV=1, every bit SHALL last one cycle and the divider SHALL stay at 0.

Reset
REQ-024 When Reset=0 on a rising edge, the FSM SHALL go to IDLE, and the divider, bit counter and internal register SHALL be cleared to 0.
REQ-025 The outputs SHALL then be Tx=1, Ready=1, Busy=0 and Done=0 in the following cycle.
REQ-026 Reset SHALL have priority over acceptance and over every state transition.
REQ-027 Reset asserted mid-frame SHALL abort the frame immediately, SHALL NOT pulse Done, and no partial frame SHALL resume after reset is released.
REQ-028 Outputs before the first reset edge are undefined; the bench SHALL apply reset before the first check.

Verification
REQ-029 Scenario 1: defaults, Reset=0 for 2 cycles -> Tx=1, Ready=1, Busy=0, Done=0.
REQ-030 Scenario 2: defaults, D=4'b1101 with Valid pulsed for 1 cycle -> Tx = 0,1,0,1,1,1,1 with each bit lasting 4 cycles (parity 1); Busy=1 for 28 cycles; Done pulses once in cycle 29.
REQ-031 Scenario 3: PARITY_EN=0, D=4'b1001 -> Tx = 0,1,0,0,1,1 with 4 cycles each; frame lasts 24 cycles.
REQ-032 Scenario 4: defaults, Valid pulsed with D=4'b0110 at cycle 10 of a frame of 1101 -> ignored; the frame stays identical to Scenario 2, and no second frame follows.
REQ-033 Scenario 5: defaults, Reset=0 at cycle 13 of a frame -> next cycle Tx=1, Busy=0, Ready=1, Done never pulses.
REQ-034 Scenario 6: DIV=1, Valid held 1, D=4'b1111 then 4'b0000 -> first frame Tx = 0,1,1,1,1,0,1, then one cycle of Tx=1 with Done=1, then second frame Tx = 0,0,0,0,0,0,1.

Source files
------------

// File: rtl/serial_framer.sv
// rtl/serial_framer.sv - parallel-to-serial framer: start bit, LSB-first data, optional even parity, stop bit
module serial_framer #(
    parameter int WIDTH     = 4,
    parameter int DIV       = 4,
    parameter int PARITY_EN = 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] D,
    input  logic             Valid,
    output logic             Ready,
    output logic             Tx,
    output logic             Busy,
    output logic             Done
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           r_state;
    logic [DW-1:0]    r_div;
    logic [BW-1:0]    r_bit;
    logic [WIDTH-1:0] r_shift;
    logic             r_parity;
    logic             r_done;

    logic             w_bit_end;
    logic             w_last_bit;

    assign w_bit_end  = (r_div == DW'(DIV - 1));
    assign w_last_bit = (r_bit == BW'(WIDTH - 1));

    // Frame sequencer: accepts a word in IDLE, then walks START/DATA/PARITY/STOP one bit period each
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            r_state  <= IDLE;
            r_div    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == IDLE) begin
                if (Valid) begin
                    r_shift  <= D;
                    r_parity <= ^D;
                    r_div    <= '0;
                    r_bit    <= '0;
                    r_state  <= START;
                end
            end else begin
                // The divider free-runs within a bit and wraps at each bit boundary
                r_div <= w_bit_end ? '0 : r_div + DW'(1);
                if (w_bit_end) begin
                    case (r_state)
                        START: r_state <= DATA;
                        DATA: begin
                            r_shift <= r_shift >> 1;
                            if (w_last_bit) begin
                                r_bit   <= '0;
                                r_state <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                r_bit <= r_bit + BW'(1);
                            end
                        end
                        PARITY: r_state <= STOP;
                        STOP: begin
                            r_state <= IDLE;
                            r_done  <= 1'b1;
                        end
                        default: r_state <= IDLE;
                    endcase
                end
            end
        end
    end

    // Line level decoded from the current state and latched word only
    always_comb begin
        Tx = 1'b1;
        case (r_state)
            START:   Tx = 1'b0;
            DATA:    Tx = r_shift[0];
            PARITY:  Tx = r_parity;
            default: Tx = 1'b1;
        endcase
    end

    assign Ready = (r_state == IDLE);
    assign Busy  = (r_state != IDLE);
    assign Done  = r_done;

endmodule

// File: tb/tb_serial_framer.sv
// tb/tb_serial_framer.sv - scoreboard bench for serial_framer in three parameter sets
module tb_serial_framer;

    typedef struct packed {
        logic tx;
        logic busy;
        logic ready;
        logic done;
    } exp_t;

    logic       clk;
    logic       rst_n;

    logic [3:0] a_d, b_d, c_d;
    logic       a_valid, b_valid, c_valid;
    logic       a_ready, a_tx, a_busy, a_done;
    logic       b_ready, b_tx, b_busy, b_done;
    logic       c_ready, c_tx, c_busy, c_done;

    exp_t       q[$];
    int         vectors;
    int         miscompares;

    serial_framer #(.WIDTH(4), .DIV(4), .PARITY_EN(1)) u_a (
        .Clock(clk), .Reset(rst_n), .D(a_d), .Valid(a_valid),
        .Ready(a_ready), .Tx(a_tx), .Busy(a_busy), .Done(a_done)
    );

    serial_framer #(.WIDTH(4), .DIV(4), .PARITY_EN(0)) u_b (
        .Clock(clk), .Reset(rst_n), .D(b_d), .Valid(b_valid),
        .Ready(b_ready), .Tx(b_tx), .Busy(b_busy), .Done(b_done)
    );

    serial_framer #(.WIDTH(4), .DIV(1), .PARITY_EN(1)) u_c (
        .Clock(clk), .Reset(rst_n), .D(c_d), .Valid(c_valid),
        .Ready(c_ready), .Tx(c_tx), .Busy(c_busy), .Done(c_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected per-cycle outputs of one frame followed by its Done cycle
    task automatic push_frame(input logic [3:0] d, input int div, input int par);
        int   n_bits;
        logic b;
        exp_t e;
        n_bits = 4 + 2 + par;
        for (int k = 0; k < n_bits; k++) begin
            if (k == 0)                    b = 1'b0;
            else if (k <= 4)               b = d[k-1];
            else if (par != 0 && k == 5)   b = d[0] ^ d[1] ^ d[2] ^ d[3];
            else                           b = 1'b1;
            for (int c = 0; c < div; c++) begin
                e = '{tx: b, busy: 1'b1, ready: 1'b0, done: 1'b0};
                q.push_back(e);
            end
        end
        e = '{tx: 1'b1, busy: 1'b0, ready: 1'b1, done: 1'b1};
        q.push_back(e);
    endtask

    task automatic test_reset();
        exp_t idle;
        idle = '{tx: 1'b1, busy: 1'b0, ready: 1'b1, done: 1'b0};
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({a_tx, a_busy, a_ready, a_done} !== idle) begin
            miscompares++;
            $display("FAIL reset_a got=%b expected=%b", {a_tx, a_busy, a_ready, a_done}, idle);
        end
        vectors++;
        if ({b_tx, b_busy, b_ready, b_done} !== idle) begin
            miscompares++;
            $display("FAIL reset_b got=%b expected=%b", {b_tx, b_busy, b_ready, b_done}, idle);
        end
        vectors++;
        if ({c_tx, c_busy, c_ready, c_done} !== idle) begin
            miscompares++;
            $display("FAIL reset_c got=%b expected=%b", {c_tx, c_busy, c_ready, c_done}, idle);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if ({a_tx, a_busy, a_ready, a_done} !== idle) begin
            miscompares++;
            $display("FAIL reset_release_a got=%b expected=%b", {a_tx, a_busy, a_ready, a_done}, idle);
        end
    endtask

    // Defaults instance; optionally pulses Valid with another word mid-frame
    task automatic test_frame_default(input string name, input logic [3:0] d, input int inject_at);
        exp_t e;
        int   i;
        a_d = d;
        a_valid = 1'b1;
        push_frame(d, 4, 1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        a_d = ~d;
        i = 1;
        while (q.size() > 0) begin
            if (inject_at != 0 && i == inject_at) begin
                a_d = 4'b0110;
                a_valid = 1'b1;
            end else begin
                a_valid = 1'b0;
            end
            e = q.pop_front();
            vectors++;
            if ({a_tx, a_busy, a_ready, a_done} !== e) begin
                miscompares++;
                $display("FAIL %s cycle=%0d got=%b expected=%b", name, i, {a_tx, a_busy, a_ready, a_done}, e);
            end
            @(posedge clk);
            #1;
            i++;
        end
        a_valid = 1'b0;
        for (int k = 0; k < 32; k++) begin
            vectors++;
            if ({a_tx, a_busy, a_done} !== 3'b100) begin
                miscompares++;
                $display("FAIL %s_after k=%0d got tx/busy/done=%b expected=100", name, k, {a_tx, a_busy, a_done});
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_no_parity();
        exp_t e;
        int   i;
        b_d = 4'b1001;
        b_valid = 1'b1;
        push_frame(4'b1001, 4, 0);
        @(posedge clk);
        #1;
        b_valid = 1'b0;
        b_d = 4'b0000;
        i = 1;
        while (q.size() > 0) begin
            e = q.pop_front();
            vectors++;
            if ({b_tx, b_busy, b_ready, b_done} !== e) begin
                miscompares++;
                $display("FAIL no_parity cycle=%0d got=%b expected=%b", i, {b_tx, b_busy, b_ready, b_done}, e);
            end
            @(posedge clk);
            #1;
            i++;
        end
        vectors++;
        if ({b_busy, b_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL no_parity_end got busy/done=%b expected=00", {b_busy, b_done});
        end
    endtask

    task automatic test_reset_mid_frame();
        exp_t e;
        a_d = 4'b1101;
        a_valid = 1'b1;
        push_frame(4'b1101, 4, 1);
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            e = q.pop_front();
            vectors++;
            if ({a_tx, a_busy, a_ready, a_done} !== e) begin
                miscompares++;
                $display("FAIL mid_reset_pre cycle=%0d got=%b expected=%b", i, {a_tx, a_busy, a_ready, a_done}, e);
            end
            if (i < 13) begin
                @(posedge clk);
                #1;
            end
        end
        q.delete();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        vectors++;
        if ({a_tx, a_busy, a_ready, a_done} !== 4'b1010) begin
            miscompares++;
            $display("FAIL mid_reset_abort got=%b expected=1010", {a_tx, a_busy, a_ready, a_done});
        end
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            vectors++;
            if ({a_tx, a_busy, a_ready, a_done} !== 4'b1010) begin
                miscompares++;
                $display("FAIL mid_reset_quiet k=%0d got=%b expected=1010", k, {a_tx, a_busy, a_ready, a_done});
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   i;
        c_d = 4'b1111;
        c_valid = 1'b1;
        push_frame(4'b1111, 1, 1);
        push_frame(4'b0000, 1, 1);
        @(posedge clk);
        #1;
        c_d = 4'b0000;
        i = 1;
        while (q.size() > 0) begin
            if (i == 9) c_valid = 1'b0;
            e = q.pop_front();
            vectors++;
            if ({c_tx, c_busy, c_ready, c_done} !== e) begin
                miscompares++;
                $display("FAIL back_to_back cycle=%0d got=%b expected=%b", i, {c_tx, c_busy, c_ready, c_done}, e);
            end
            @(posedge clk);
            #1;
            i++;
        end
        c_valid = 1'b0;
        vectors++;
        if ({c_tx, c_busy, c_done} !== 3'b100) begin
            miscompares++;
            $display("FAIL back_to_back_end got tx/busy/done=%b expected=100", {c_tx, c_busy, c_done});
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        a_d = '0; b_d = '0; c_d = '0;
        a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_frame_default("frame_1101", 4'b1101, 0);
        test_no_parity();
        test_frame_default("ignore_valid", 4'b1101, 10);
        test_frame_default("frame_0010", 4'b0010, 0);
        test_reset_mid_frame();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
